config_frame_loader: RTL
========================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 32, number of frame strobes per column (2..32).
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, width of frame data word.
REQ-003 SHALL have parameter STROBE_CYCLES, default 1, strobe pulse length in cycles (1..15).
REQ-004 SHALL have port UserCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_valid  input  1  requester presents a frame write.
REQ-007 SHALL have port frame_ready  output  1  loader can accept a frame write.
REQ-008 SHALL have port frame_addr  input  8  target frame index.
REQ-009 SHALL have port frame_data  input  FrameBitsPerRow  frame word to load.
REQ-010 SHALL have port FrameData  output  FrameBitsPerRow  registered data driven to tile column.
REQ-011 SHALL have port FrameStrobe  output  MaxFramesPerCol  registered one-hot strobe to tile column.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port addr_err  output  1  sticky out-of-range address flag.
REQ-014 SHALL have port clear_err  input  1  clears addr_err.
REQ-015 SHALL have port frame_count  output  16  number of frames fully loaded, saturating.

Function
REQ-016 SHALL implement states IDLE, SETUP, STROBE, HOLD.
REQ-017 SHALL drive frame_ready high only in IDLE; a transfer occurs when frame_valid and frame_ready are both high at an edge.
REQ-018 On a transfer with frame_addr < MaxFramesPerCol at edge T, SHALL register frame_data into FrameData and frame_addr internally, and enter SETUP at T+1.
REQ-019 SETUP SHALL last exactly 1 cycle with FrameStrobe all-zero and FrameData stable.
REQ-020 STROBE SHALL last exactly STROBE_CYCLES cycles with FrameStrobe[addr]=1 and all other bits 0; cycle count uses a 4-bit down-counter.
REQ-021 HOLD SHALL last exactly 1 cycle with FrameStrobe all-zero and FrameData stable, then return to IDLE.
REQ-022 Transfer-to-next-ready latency SHALL be STROBE_CYCLES+3 cycles; FrameData SHALL change only on an accepted in-range transfer.
REQ-023 frame_count SHALL increment by 1 on the HOLD->IDLE edge, saturating at 16'hFFFF.
REQ-024 A transfer with frame_addr >= MaxFramesPerCol SHALL be consumed (ready handshake completes), remain in IDLE, leave FrameData/FrameStrobe/frame_count unchanged, and set addr_err.
REQ-025 clear_err SHALL clear addr_err at the next edge; if set and clear occur in the same cycle, set SHALL win.
REQ-026 frame_valid, frame_addr, frame_data SHALL be ignored outside IDLE; input changes SHALL NOT affect an in-flight frame.
REQ-027 FrameStrobe SHALL never have more than one bit set in any cycle.

Reset
REQ-028 Reset high at an edge SHALL force IDLE, FrameStrobe=0, FrameData=0, frame_count=0, addr_err=0, strobe counter=0.
REQ-029 Reset SHALL take priority over transfers, clear_err, and any in-flight state; a strobe interrupted by Reset SHALL drop at that edge and no count increment occurs.
REQ-030 While Reset is high, frame_ready SHALL be 0 and busy SHALL be 0.

Verification
REQ-031 Single write, STROBE_CYCLES=1: addr=5, data=32'hA5A5_0001 accepted at T -> FrameData=A5A5_0001 from T+1, FrameStrobe=32'h0000_0020 in cycle T+2 only, ready high again at T+4, frame_count=1.
REQ-032 STROBE_CYCLES=4, addr=31: strobe bit 31 high for exactly 4 consecutive cycles, period 7 cycles, back-to-back valid gives one transfer per 7 cycles.
REQ-033 Out-of-range addr=32 (default params): handshake completes, no strobe, FrameData unchanged, addr_err=1; clear_err pulse -> addr_err=0 next cycle; simultaneous bad transfer and clear_err -> addr_err stays 1.
REQ-034 Reset asserted during STROBE: FrameStrobe=0 and state IDLE at that edge, frame_count=0, ready high one cycle after Reset deasserts.
REQ-035 Inputs toggled during SETUP/STROBE/HOLD: FrameData and strobe index unchanged; frame_ready stays 0.
REQ-036 Preload frame_count to 16'hFFFE via 2 writes after forcing: two further writes -> count reads 16'hFFFF and stays.

Source files
------------

// File: rtl/config_frame_loader.sv
// Loads one frame word per accepted request and pulses its one-hot strobe for STROBE_CYCLES cycles.
// Latency: transfer-to-next-ready is STROBE_CYCLES+3 cycles; frame_ready is low while a frame is in flight.
module config_frame_loader #(
    parameter int MaxFramesPerCol = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int STROBE_CYCLES   = 1
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [7:0]                 frame_addr,
    input  logic [FrameBitsPerRow-1:0] frame_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       addr_err,
    input  logic                       clear_err,
    output logic [15:0]                frame_count
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [7:0] ADDR_LIMIT  = 8'(MaxFramesPerCol);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t                     state;
    logic [7:0]                 addr_q;
    logic [3:0]                 strobe_cnt;
    logic [15:0]                frame_cnt_q;
    logic [MaxFramesPerCol-1:0] strobe_sel;
    logic                       accept;
    logic                       in_range;

    assign frame_ready = (state == IDLE) && !Reset;
    assign busy        = (state != IDLE) && !Reset;
    assign accept      = frame_valid && frame_ready;
    assign in_range    = frame_addr < ADDR_LIMIT;
    assign frame_count = frame_cnt_q;

    // Decode from the latched address so requester changes cannot move an in-flight strobe.
    always_comb begin
        strobe_sel = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            strobe_sel[i] = (addr_q == 8'(i));
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            strobe_cnt  <= '0;
            frame_cnt_q <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            addr_err    <= 1'b0;
        end else begin
            // A bad address arriving with clear_err keeps the flag set.
            if (accept && !in_range) begin
                addr_err <= 1'b1;
            end else if (clear_err) begin
                addr_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && in_range) begin
                        FrameData <= frame_data;
                        addr_q    <= frame_addr;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    FrameStrobe <= strobe_sel;
                    strobe_cnt  <= STROBE_LOAD;
                    state       <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        FrameStrobe <= '0;
                        state       <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
